// File: rtl/load_store_unit.sv
// Load/store initiator for the word-addressed data_memory: byte-addressed requests in,
// word strobes out, with read-modify-write for byte/halfword stores and extended load results.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clkn,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    // Handshake: a request transfers on a rising clkn edge where req_valid && req_ready;
    // req_ready is high only in IDLE and the response is a one-cycle resp_valid pulse
    // with no backpressure.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t                state_q, state_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_read_q, mem_read_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  req_bad;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] merged;

    assign req_ready = (state_q == IDLE);

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SIZE_BYTE: req_bad = 1'b0;
            SIZE_HALF: req_bad = req_addr[0];
            SIZE_WORD: req_bad = (req_addr[1:0] != 2'b00);
            default:   req_bad = 1'b1;
        endcase
    end

    // Lane extraction and extension of the returned word for loads.
    always_comb begin
        rd_byte = mem_read_data[7:0];
        case (lane_q)
            2'd0:    rd_byte = mem_read_data[7:0];
            2'd1:    rd_byte = mem_read_data[15:8];
            2'd2:    rd_byte = mem_read_data[23:16];
            default: rd_byte = mem_read_data[31:24];
        endcase
        rd_half = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            SIZE_BYTE: load_ext = {{24{rd_byte[7] & ~unsigned_q}}, rd_byte};
            SIZE_HALF: load_ext = {{16{rd_half[15] & ~unsigned_q}}, rd_half};
            default:   load_ext = mem_read_data;
        endcase
    end

    // Sub-word store merge: replace only the addressed lane of the word just read.
    always_comb begin
        shamt     = {lane_q, 3'b000};
        lane_mask = (size_q == SIZE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
        lane_mask = lane_mask << shamt;
        merged    = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_comb begin
        state_d          = state_q;
        resp_valid_d     = 1'b0;
        resp_err_d       = 1'b0;
        resp_rdata_d     = '0;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        size_d           = size_q;
        unsigned_d       = unsigned_q;
        lane_d           = lane_q;
        wdata_d          = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        // Rejected without touching memory; stay ready for the next request.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        size_d        = req_size;
                        unsigned_d    = req_unsigned;
                        lane_d        = req_addr[1:0];
                        wdata_d       = req_wdata;
                        mem_address_d = {2'b00, req_addr[ADDR_WIDTH-1:2]};
                        if (!req_we) begin
                            mem_read_d = 1'b1;
                            state_d    = LOAD;
                        end else if (req_size == SIZE_WORD) begin
                            mem_write_d      = 1'b1;
                            mem_write_data_d = req_wdata;
                            state_d          = STORE;
                        end else begin
                            mem_read_d = 1'b1;
                            state_d    = RMW_RD;
                        end
                    end
                end
            end
            LOAD: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
                state_d      = IDLE;
            end
            STORE: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            RMW_RD: begin
                mem_write_d      = 1'b1;
                mem_write_data_d = merged;
                state_d          = RMW_WR;
            end
            RMW_WR: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkn) begin
        if (rst) begin
            state_q          <= IDLE;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            size_q           <= 2'b00;
            unsigned_q       <= 1'b0;
            lane_q           <= 2'b00;
            wdata_q          <= '0;
        end else begin
            state_q          <= state_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
            size_q           <= size_d;
            unsigned_q       <= unsigned_d;
            lane_q           <= lane_d;
            wdata_q          <= wdata_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a falling-edge data_memory model and an
// in-order response scoreboard for back-to-back traffic.
module tb_load_store_unit;

    logic        clkn;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];
    int          rd_cycles   = 0;
    int          wr_cycles   = 0;
    int          resp_cycles = 0;
    logic        overlap     = 1'b0;

    logic [32:0] exp_q[$];

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clkn           (clkn),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    // clock / reset
    initial begin
        clkn = 1'b0;
        forever #5 clkn = ~clkn;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1);
    end

    // data_memory model: samples strobes on the falling edge
    always @(negedge clkn) begin
        if (mem_write) mem[mem_address[5:0]] <= mem_write_data;
        if (mem_read)  mem_read_data <= mem[mem_address[5:0]];
        if (mem_read)  rd_cycles <= rd_cycles + 1;
        if (mem_write) wr_cycles <= wr_cycles + 1;
        if (resp_valid) resp_cycles <= resp_cycles + 1;
        if (mem_read && mem_write) overlap <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // One request, checked cycle by cycle; exp_word is the memory word after a store.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input logic [31:0] exp_word);
        int lat;
        int rd0;
        int wr0;
        int rd_exp;
        int wr_exp;
        lat    = exp_err ? 0 : ((we && size != 2'b10) ? 2 : 1);
        rd_exp = (exp_err || (we && size == 2'b10)) ? 0 : 1;
        wr_exp = (we && !exp_err) ? 1 : 0;
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        check({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
        set_req(we, size, uns, addr, wdata);
        req_valid = 1'b1;
        @(posedge clkn); #1;
        req_valid = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, "/early_resp"}, {31'd0, resp_valid}, 32'd0);
            check({tag, "/mem_address"}, mem_address, addr >> 2);
            if (i == 0 && rd_exp == 1)
                check({tag, "/mem_read"}, {31'd0, mem_read}, 32'd1);
            if (we && i == lat - 1) begin
                check({tag, "/mem_write"}, {31'd0, mem_write}, 32'd1);
                check({tag, "/mem_write_data"}, mem_write_data, exp_word);
            end
            @(posedge clkn); #1;
        end
        check({tag, "/resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "/resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, "/resp_rdata"}, resp_rdata, exp_rdata);
        check({tag, "/strobes_idle"}, {30'd0, mem_read, mem_write}, 32'd0);
        @(posedge clkn); #1;
        check({tag, "/resp_drop"}, {30'd0, resp_valid, resp_err}, 32'd0);
        check({tag, "/rd_cycles"}, rd_cycles - rd0, rd_exp);
        check({tag, "/wr_cycles"}, wr_cycles - wr0, wr_exp);
        if (we && !exp_err)
            check({tag, "/mem_word"}, mem[addr[7:2]], exp_word);
    endtask

    // back-to-back traffic with req_valid held high
    task automatic run_stream();
        logic        we_t  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz_t  [5] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
        logic        un_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ad_t  [5] = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h42};
        logic [31:0] wd_t  [5] = '{32'hCAFEBABE, 32'h0, 32'h00000077, 32'h0, 32'h0};
        logic        er_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] rd_t  [5] = '{32'h0, 32'h000000BA, 32'h0, 32'h0, 32'hFFFFCA77};
        for (int k = 0; k < 5; k++) exp_q.push_back({er_t[k], rd_t[k]});
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    int w;
                    set_req(we_t[k], sz_t[k], un_t[k], ad_t[k], wd_t[k]);
                    req_valid = 1'b1;
                    w = 0;
                    while (!req_ready && w < 20) begin
                        @(posedge clkn); #1;
                        w++;
                    end
                    check("t6/ready_wait", {31'd0, (w < 20)}, 32'd1);
                    @(posedge clkn); #1;
                    if (!er_t[k]) check("t6/busy", {31'd0, req_ready}, 32'd0);
                end
                req_valid = 1'b0;
            end
            begin
                int got;
                logic [32:0] e;
                got = 0;
                for (int c = 0; c < 80 && got < 5; c++) begin
                    @(negedge clkn);
                    if (resp_valid) begin
                        if (exp_q.size() == 0) begin
                            check("t6/extra_resp", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("t6/sb_err", {31'd0, resp_err}, {31'd0, e[32]});
                            check("t6/sb_rdata", resp_rdata, e[31:0]);
                        end
                        got++;
                    end
                end
                check("t6/resp_count", got, 32'd5);
            end
        join
        repeat (3) @(posedge clkn);
        #1;
        check("t6/no_late_resp", {31'd0, resp_valid}, 32'd0);
        check("t6/mem_word", mem[16], 32'hCA77BABE);
    endtask

    initial begin
        int wr0;
        int resp0;
        rst       = 1'b1;
        req_valid = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clkn);
        #1;
        check("rst/ready", {31'd0, req_ready}, 32'd1);
        check("rst/resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst/resp_rdata", resp_rdata, 32'd0);
        check("rst/mem_address", mem_address, 32'd0);
        check("rst/mem_write_data", mem_write_data, 32'd0);
        check("rst/strobes", {30'd0, mem_read, mem_write}, 32'd0);
        rst = 1'b0;
        @(posedge clkn); #1;

        // 1: word store then word load
        do_req("t1/sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF);
        do_req("t1/lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0);

        // 2: byte store via read-modify-write
        do_req("t2/sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, 32'h11223344);
        do_req("t2/sb", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 1'b0, 32'h0, 32'h1122A544);

        // 3: extension
        do_req("t3/sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF0000, 1'b0, 32'h0, 32'h80FF0000);
        do_req("t3/lb", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80, 32'h0);
        do_req("t3/lbu", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h00000080, 32'h0);
        do_req("t3/lh", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF80FF, 32'h0);
        do_req("t3/lhu", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h000080FF, 32'h0);
        do_req("t3/sh", 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234BEEF, 1'b0, 32'h0, 32'h80FFBEEF);
        do_req("t3/lb0", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 32'h0);

        // 4: error requests
        do_req("t4/lw_mis", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 32'h0);
        do_req("t4/lh_mis", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0, 32'h0);
        do_req("t4/rsvd", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0, 32'h0);
        do_req("t4/sw_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1'b1, 32'h0, 32'h0);

        // 5: reset during the read half of a halfword store
        do_req("t5/sw", 1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, 1'b0, 32'h0, 32'h55667788);
        wr0   = wr_cycles;
        resp0 = resp_cycles;
        set_req(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000ABCD);
        req_valid = 1'b1;
        @(posedge clkn); #1;
        req_valid = 1'b0;
        check("t5/rmw_rd", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        @(posedge clkn); #1;
        rst = 1'b0;
        check("t5/strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("t5/ready", {31'd0, req_ready}, 32'd1);
        check("t5/resp", {31'd0, resp_valid}, 32'd0);
        repeat (3) @(posedge clkn);
        #1;
        check("t5/no_write", wr_cycles - wr0, 32'd0);
        check("t5/no_resp", resp_cycles - resp0, 32'd0);
        check("t5/mem_word", mem[8], 32'h55667788);
        do_req("t5/lw", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h55667788, 32'h0);

        // 6: streamed mixed requests
        run_stream();

        check("inv/rd_wr_overlap", {31'd0, overlap}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data_memory word interface. Accepts load/store requests (byte, halfword, word; signed/unsigned loads) from the MIPS pipeline using byte addresses, and drives the word-addressed memory strobes. Sub-word stores are implemented as read-modify-write. Load results are sign- or zero-extended. The block sits between the execute stage and data_memory.

Parameters:
ADDR_WIDTH, 32, width of the byte address and of mem_address.
DATA_WIDTH, 32, data width. Fixed at 32 because the lane logic is 4 bytes.

Ports:
clkn  input  1  clock; all state updates on rising edge of clkn; data_memory samples on the falling edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block idle and able to accept; combinational, equals (state==IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  zero-extend the load result (lbu/lhu)
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, taken from the low bits for sub-word stores
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  misaligned or reserved-size request; qualified by resp_valid
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
mem_address  output  ADDR_WIDTH  word address = req_addr >> 2, zero-extended
mem_write_data  output  DATA_WIDTH  word to write
mem_write  output  1  write strobe
mem_read  output  1  read strobe
mem_read_data  input  DATA_WIDTH  data_memory Read_data

Behaviour:
- Interface decision: one clock, clkn; reset rst is synchronous and active-high.
- Reset: state=IDLE. resp_valid, resp_err, resp_rdata, mem_address, mem_write_data, mem_write and mem_read are all 0.
- All outputs except req_ready are registered.
- Handshake: a request is accepted at a rising edge where req_valid && req_ready. Request fields are captured into internal registers at acceptance. There is no backpressure on the response.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], lane = addr[1:0]. Halfword lane = addr[1].
- Error condition: a half access with addr[0]=1, a word access with addr[1:0]!=0, or size=11.
- Error handling: at the acceptance edge N, set resp_valid=1, resp_err=1, resp_rdata=0. No memory strobe is asserted and the state stays IDLE.
- State machine:
  - IDLE, load accepted at edge N: mem_read<=1, mem_address set, go to LOAD.
  - LOAD, edge N+1: capture mem_read_data (written by data_memory at the intervening falling edge), extract and extend the lane into resp_rdata, resp_valid<=1, mem_read<=0, go to IDLE.
  - IDLE, word store accepted at edge N: mem_write<=1, mem_write_data=req_wdata, go to STORE.
  - STORE, edge N+1: mem_write<=0, resp_valid<=1, go to IDLE.
  - IDLE, byte/half store accepted at edge N: mem_read<=1, go to RMW_RD.
  - RMW_RD, edge N+1: merge the new lane into mem_read_data and load the result into mem_write_data; mem_read<=0, mem_write<=1, go to RMW_WR.
  - RMW_WR, edge N+2: mem_write<=0, resp_valid<=1, go to IDLE.
- Latency: load 1 cycle; word store 1 cycle; sub-word store 2 cycles; error 0 cycles (response registered at the acceptance edge).
- resp_valid and resp_err return to 0 on the edge after any pulse.
- Throughput: the next request can be accepted at the edge after the one that returns the state to IDLE. Error requests may be accepted back-to-back.
- Invariants:
  - mem_read and mem_write are never 1 simultaneously.
  - mem_address and mem_write_data are stable while a strobe is high.
- Extension:
  - lb: bits 31:8 = bit 7 of the byte.
  - lbu: bits 31:8 = 0.
  - lh/lhu: the same rule on bit 15.
- Reset mid-operation (any state): the next edge forces IDLE and clears all strobes before the following falling edge. An in-flight RMW write is dropped and memory is unchanged. No resp_valid is produced for the aborted request.
- A request held on req_valid while req_ready=0 is ignored until IDLE.

Test Plan:
1. sw 0xDEADBEEF @0x10, then lw @0x10 -> mem_address=4 with mem_write high for exactly 1 cycle; load resp_valid pulse 1 cycle after acceptance with resp_rdata=0xDEADBEEF, resp_err=0.
2. Word 4 = 0x11223344; sb 0x000000A5 @0x11 -> mem_read for 1 cycle, then mem_write with data 0x1122A544; resp_valid 2 cycles after acceptance.
3. Word 4 = 0x80FF0000 -> lb @0x13 gives 0xFFFFFF80; lbu @0x13 gives 0x00000080; lh @0x12 gives 0xFFFF80FF; lhu @0x12 gives 0x000080FF.
4. lw @0x06, lh @0x03, size=11 @0x00 -> each: resp_valid=1 and resp_err=1 at the acceptance edge, resp_rdata=0, mem_read=mem_write=0 throughout.
5. sh @0x20 with rst asserted in the RMW_RD cycle -> mem_write never asserts, memory word unchanged, no resp_valid, req_ready=1 after the reset edge.
6. req_valid held high across 5 mixed requests -> req_ready low while busy, each request served exactly once in order, mem_read&&mem_write never 1 (assertion).
